// File: rtl/fb_read_arbiter.sv
// fb_read_arbiter: shares the framebuffer RAM read port between the VGA
// pixel fetcher (port A, always wins) and a secondary reader (port B).
// Read data is routed back through a {valid, owner} tag pipeline that is
// READ_LAT deep, so A latency is always READ_LAT+1 cycles.
// Optional build macro ARB_STATS_EN adds grant/stall statistics counters
// (stat_a_grants, stat_b_grants, stat_b_stall) and a stat_clr input.
//
// Port B handshake: a request transfers in a cycle where b_valid && b_ready;
// b_addr must hold while b_valid && !b_ready. Only one request is outstanding:
// the response is presented as b_rvalid/b_rdata, held until the cycle where
// b_rvalid && b_rready, and the next b_ready can come the cycle after that.
module fb_read_arbiter #(
  parameter int ADDR_W   = 18,
  parameter int DATA_W   = 8,
  parameter int READ_LAT = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  output logic              b_ready,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  input  logic              b_rready,
  output logic [ADDR_W-1:0] rdaddress,
  input  logic [DATA_W-1:0] q,
  output logic [1:0]        b_state_dbg
`ifdef ARB_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [31:0]       stat_a_grants,
  output logic [31:0]       stat_b_grants,
  output logic [31:0]       stat_b_stall
`endif
);

  typedef enum logic [1:0] {
    B_IDLE = 2'd0,
    B_WAIT = 2'd1,
    B_RESP = 2'd2
  } b_state_e;

  b_state_e            b_state_q, b_state_d;
  logic [ADDR_W-1:0]   rdaddress_q, rdaddress_d;
  logic [READ_LAT-1:0] tag_vld_q, tag_vld_d;
  logic [READ_LAT-1:0] tag_own_q, tag_own_d;   // 1 = port B owns the slot
  logic                a_rvalid_q, a_rvalid_d;
  logic [DATA_W-1:0]   a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0]   b_rdata_q, b_rdata_d;
  logic                grant_a, grant_b;
  logic                tail_a, tail_b;

  // Fixed priority grant: A whenever it asks, B only when A is idle and B has nothing pending.
  always_comb begin
    grant_a = a_req;
    grant_b = !a_req && (b_state_q == B_IDLE) && b_valid;
    tail_a  = tag_vld_q[READ_LAT-1] && !tag_own_q[READ_LAT-1];
    tail_b  = tag_vld_q[READ_LAT-1] &&  tag_own_q[READ_LAT-1];
  end

  // Address mux, tag shift register and read-data capture at the pipeline tail.
  always_comb begin
    rdaddress_d = rdaddress_q;
    if (grant_a)      rdaddress_d = a_addr;
    else if (grant_b) rdaddress_d = b_addr;
    tag_vld_d    = '0;
    tag_own_d    = '0;
    tag_vld_d[0] = grant_a || grant_b;
    tag_own_d[0] = grant_b;
    for (int i = 1; i < READ_LAT; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_own_d[i] = tag_own_q[i-1];
    end
    a_rvalid_d = tail_a;
    a_rdata_d  = tail_a ? q : a_rdata_q;
    b_rdata_d  = tail_b ? q : b_rdata_q;
  end

  // Port B FSM next state: one outstanding request, response held until consumed.
  always_comb begin
    b_state_d = b_state_q;
    case (b_state_q)
      B_IDLE:  if (grant_b)  b_state_d = B_WAIT;
      B_WAIT:  if (tail_b)   b_state_d = B_RESP;
      B_RESP:  if (b_rready) b_state_d = B_IDLE;
      default:               b_state_d = B_IDLE;
    endcase
  end

  // State registers; reset discards in-flight tags and any pending B response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      b_state_q   <= B_IDLE;
      rdaddress_q <= '0;
      tag_vld_q   <= '0;
      tag_own_q   <= '0;
      a_rvalid_q  <= 1'b0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
    end else begin
      b_state_q   <= b_state_d;
      rdaddress_q <= rdaddress_d;
      tag_vld_q   <= tag_vld_d;
      tag_own_q   <= tag_own_d;
      a_rvalid_q  <= a_rvalid_d;
      a_rdata_q   <= a_rdata_d;
      b_rdata_q   <= b_rdata_d;
    end
  end

  assign rdaddress   = rdaddress_q;
  assign a_rvalid    = a_rvalid_q;
  assign a_rdata     = a_rdata_q;
  assign b_ready     = grant_b;
  assign b_rvalid    = (b_state_q == B_RESP);
  assign b_rdata     = b_rdata_q;
  assign b_state_dbg = b_state_q;

`ifdef ARB_STATS_EN
  logic [31:0] stat_a_q, stat_a_d;
  logic [31:0] stat_b_q, stat_b_d;
  logic [31:0] stat_s_q, stat_s_d;
  logic        b_stall;

  // Saturating statistics counters; a synchronous clear beats an increment.
  always_comb begin
    b_stall  = b_valid && (b_state_q == B_IDLE) && a_req;
    stat_a_d = stat_a_q;
    stat_b_d = stat_b_q;
    stat_s_d = stat_s_q;
    if (stat_clr) begin
      stat_a_d = '0;
      stat_b_d = '0;
      stat_s_d = '0;
    end else begin
      if (grant_a && (stat_a_q != 32'hFFFF_FFFF)) stat_a_d = stat_a_q + 32'd1;
      if (grant_b && (stat_b_q != 32'hFFFF_FFFF)) stat_b_d = stat_b_q + 32'd1;
      if (b_stall && (stat_s_q != 32'hFFFF_FFFF)) stat_s_d = stat_s_q + 32'd1;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_a_q <= '0;
      stat_b_q <= '0;
      stat_s_q <= '0;
    end else begin
      stat_a_q <= stat_a_d;
      stat_b_q <= stat_b_d;
      stat_s_q <= stat_s_d;
    end
  end

  assign stat_a_grants = stat_a_q;
  assign stat_b_grants = stat_b_q;
  assign stat_b_stall  = stat_s_q;
`endif

endmodule

// File: tb/tb_fb_read_arbiter.sv
// Bench for fb_read_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level reference model.
module tb_fb_read_arbiter;

  localparam int ADDR_W   = 18;
  localparam int DATA_W   = 8;
  localparam int READ_LAT = 2;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              a_req;
  logic [ADDR_W-1:0] a_addr;
  logic              a_rvalid;
  logic [DATA_W-1:0] a_rdata;
  logic              b_valid;
  logic [ADDR_W-1:0] b_addr;
  logic              b_ready;
  logic              b_rvalid;
  logic [DATA_W-1:0] b_rdata;
  logic              b_rready;
  logic [ADDR_W-1:0] rdaddress;
  logic [DATA_W-1:0] q;
  logic [1:0]        b_state_dbg;
`ifdef ARB_STATS_EN
  logic              stat_clr;
  logic [31:0]       stat_a_grants, stat_b_grants, stat_b_stall;
  int                m_a_gr, m_b_gr, m_stall;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  fb_read_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(READ_LAT)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_req(a_req), .a_addr(a_addr), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_valid(b_valid), .b_addr(b_addr), .b_ready(b_ready),
    .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_rready(b_rready),
    .rdaddress(rdaddress), .q(q), .b_state_dbg(b_state_dbg)
`ifdef ARB_STATS_EN
    , .stat_clr(stat_clr), .stat_a_grants(stat_a_grants),
    .stat_b_grants(stat_b_grants), .stat_b_stall(stat_b_stall)
`endif
  );

  // ---------------- clock / reset / RAM ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DATA_W-1:0] ram_data(input logic [ADDR_W-1:0] a);
    if (a == 18'h00010) return 8'hA5;
    if (a == 18'h3FFFF) return 8'h5A;
    return a[7:0] ^ a[15:8] ^ {6'd0, a[17:16]} ^ 8'h3C;
  endfunction

  // RAM with READ_LAT=2: one register stage after the registered rdaddress.
  always @(posedge clk) q <= ram_data(rdaddress);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  logic [DATA_W-1:0] exp_q[$];       // expected A data, in issue order
  int                exp_due_q[$];   // cycle each A response is due
  logic              b_out;          // B request outstanding (issued, not yet consumed)
  int                b_due;
  logic [DATA_W-1:0] b_exp_data, a_last, b_last;
  logic [ADDR_W-1:0] exp_rdaddr;
  int a_pulses = 0, exp_a_pulses = 0, b_grants = 0;
  int last_b_grant_cyc = -1, last_b_hs_cyc = -1;
  logic exp_b_ready, exp_a_rv, exp_b_rv;

  always @(negedge clk) begin
    if (!reset_n) begin
      chk("rst_a_rvalid", 32'(a_rvalid), 0);
      chk("rst_a_rdata", 32'(a_rdata), 0);
      chk("rst_b_rvalid", 32'(b_rvalid), 0);
      chk("rst_b_rdata", 32'(b_rdata), 0);
      chk("rst_b_ready", 32'(b_ready), 0);
      chk("rst_rdaddress", 32'(rdaddress), 0);
      exp_q.delete(); exp_due_q.delete();
      b_out = 0; exp_rdaddr = '0; a_last = '0; b_last = '0;
`ifdef ARB_STATS_EN
      m_a_gr = 0; m_b_gr = 0; m_stall = 0;
`endif
    end else begin
      exp_b_ready = b_valid && !a_req && !b_out;
      chk("b_ready", 32'(b_ready), 32'(exp_b_ready));
      chk("rdaddress", 32'(rdaddress), 32'(exp_rdaddr));
      exp_a_rv = (exp_due_q.size() > 0) && (exp_due_q[0] == cyc);
      if (exp_a_rv) begin
        a_last = exp_q.pop_front();
        void'(exp_due_q.pop_front());
        exp_a_pulses++;
      end
      chk("a_rvalid", 32'(a_rvalid), 32'(exp_a_rv));
      chk("a_rdata", 32'(a_rdata), 32'(a_last));
      exp_b_rv = b_out && (cyc >= b_due);
      if (exp_b_rv) b_last = b_exp_data;
      chk("b_rvalid", 32'(b_rvalid), 32'(exp_b_rv));
      chk("b_rdata", 32'(b_rdata), 32'(b_last));
`ifdef ARB_STATS_EN
      chk("stat_a", stat_a_grants, m_a_gr);
      chk("stat_b", stat_b_grants, m_b_gr);
      chk("stat_stall", stat_b_stall, m_stall);
      if (stat_clr) begin
        m_a_gr = 0; m_b_gr = 0; m_stall = 0;
      end else begin
        m_a_gr  += int'(a_req);
        m_b_gr  += int'(exp_b_ready);
        m_stall += int'(b_valid && !b_out && a_req);
      end
`endif
      // observations of the DUT for directed checks
      if (a_rvalid) a_pulses++;
      if (b_ready) begin last_b_grant_cyc = cyc; b_grants++; end
      if (b_rvalid && b_rready) last_b_hs_cyc = cyc;
      // advance the model
      if (exp_b_rv && b_rready) b_out = 0;
      if (a_req) begin
        exp_q.push_back(ram_data(a_addr));
        exp_due_q.push_back(cyc + READ_LAT + 1);
        exp_rdaddr = a_addr;
      end else if (exp_b_ready) begin
        b_out = 1; b_due = cyc + READ_LAT + 1;
        b_exp_data = ram_data(b_addr);
        exp_rdaddr = b_addr;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    a_req = 0; b_valid = 0;
    repeat (n) tick();
  endtask

  // Presents one B request and holds it until accepted (bounded wait).
  task automatic b_req(input logic [ADDR_W-1:0] addr, input string tag);
    logic granted = 0;
    b_valid = 1; b_addr = addr;
    for (int i = 0; i < 60 && !granted; i++) begin
      @(negedge clk);
      if (b_ready) granted = 1;
      tick();
    end
    b_valid = 0;
    chk(tag, 32'(granted), 1);
  endtask

  int a0, g0, t0, stream_end;
  logic keep;

  initial begin
    reset_n = 0; a_req = 0; a_addr = '0; b_valid = 0; b_addr = '0; b_rready = 1;
`ifdef ARB_STATS_EN
    stat_clr = 0;
`endif
    repeat (3) tick();
    reset_n = 1;
    idle(3);

    // single A read of address 0x10
    a_req = 1; a_addr = 18'h00010; t0 = cyc;
    tick(); a_req = 0;
    repeat (4) tick();
    @(negedge clk);
    chk("single_a_rdata", 32'(a_rdata), 32'h A5);
    chk("single_rdaddress", 32'(rdaddress), 32'h00010);
    tick();

    // 640-cycle A stream with B waiting throughout
    a0 = a_pulses; g0 = b_grants;
    b_valid = 1; b_addr = 18'h00155;
    for (int i = 0; i < 640; i++) begin
      a_req = 1; a_addr = ADDR_W'(i);
      tick();
    end
    a_req = 0; stream_end = cyc;
    tick(); b_valid = 0;
    idle(6);
    chk("stream_a_pulses", 32'(a_pulses - a0), 640);
    chk("stream_b_grants", 32'(b_grants - g0), 1);
    chk("stream_b_grant_cyc", 32'(last_b_grant_cyc), 32'(stream_end));

    // B read with a slow consumer, then a second request behind it
    b_rready = 0;
    b_req(18'h3FFFF, "b_slow_grant");
    repeat (5) tick();
    @(negedge clk);
    chk("b_slow_rvalid", 32'(b_rvalid), 1);
    chk("b_slow_rdata", 32'(b_rdata), 32'h5A);
    tick();
    fork
      b_req(18'h00022, "b_second_grant");
      begin repeat (3) tick(); b_rready = 1; end
    join
    chk("b_second_after_hs", 32'(last_b_grant_cyc), 32'(last_b_hs_cyc + 1));
    idle(6);

    // B granted, then A on the next three cycles: routing check
    b_valid = 1; b_addr = 18'h01234; t0 = cyc;
    tick(); b_valid = 0;
    for (int i = 0; i < 3; i++) begin
      a_req = 1; a_addr = ADDR_W'(18'h00100 + i);
      tick();
    end
    idle(8);
    chk("mix_b_grant_cyc", 32'(last_b_grant_cyc), 32'(t0));

    // reset while an A and a B read are in flight
    a_req = 1; a_addr = 18'h00200; tick();
    a_req = 0; b_valid = 1; b_addr = 18'h00300; tick();
    b_valid = 0; reset_n = 0; a0 = a_pulses;
    repeat (2) tick();
    reset_n = 1;
    idle(6);
    chk("rst_no_a_pulse", 32'(a_pulses - a0), 0);
    b_req(18'h00040, "b_after_reset_grant");
    idle(6);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      a_req  = ($urandom_range(0, 9) < 4);
      a_addr = ADDR_W'($urandom_range(0, 262143));
      keep = b_valid && (last_b_grant_cyc != cyc - 1) && ($urandom_range(0, 15) != 0);
      if (!keep) begin
        b_valid = (!b_valid) && ($urandom_range(0, 2) == 0);
        b_addr  = ADDR_W'($urandom_range(0, 262143));
      end
      b_rready = $urandom_range(0, 1) == 1;
`ifdef ARB_STATS_EN
      stat_clr = (i == 700);
`endif
      tick();
    end
`ifdef ARB_STATS_EN
    stat_clr = 0;
`endif
    b_rready = 1;
    idle(10);
    chk("a_pulse_total", 32'(a_pulses), 32'(exp_a_pulses));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
